// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the multiplier-product accumulator and its helpers.
// State encoding, default operand width and the signed-add overflow rule.
package mac_accumulator_pkg;

    localparam int WIDTH  = 8;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Two's-complement overflow: operands agree in sign, the sum does not.
    function automatic logic signed_add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Bundle between the product source / result consumer and the accumulator.
// slave is the accumulator side, master is the side that drives products and acc_ready.
interface mac_accumulator_if #(
    parameter int WIDTH     = mac_accumulator_pkg::WIDTH,
    parameter int ACC_WIDTH = 20,
    parameter int CNT_W     = 8
);
    logic                   start;
    logic [2*WIDTH-1:0]     prod_in;
    logic                   prod_rdy;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   acc_valid;
    logic                   acc_ready;
    logic                   busy;
    logic                   ovf;
    logic                   drop;
    logic [CNT_W-1:0]       count;

    modport slave (
        input  start, prod_in, prod_rdy, acc_ready,
        output acc_out, acc_valid, busy, ovf, drop, count
    );

    modport master (
        output start, prod_in, prod_rdy, acc_ready,
        input  acc_out, acc_valid, busy, ovf, drop, count
    );
endinterface

// File: rtl/mac_accumulator_rdy_edge_detect.sv
// One-cycle pulse on the rising edge of a completion level; no pulse while it stays high.
// Pulse is combinational in the cycle the level rises; the level is registered for the next cycle.
module mac_accumulator_rdy_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic rdy_i,
    output logic evt_o
);
    logic rdy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy_i;
        end
    end

    assign evt_o = rdy_i & ~rdy_q;

endmodule

// File: rtl/mac_accumulator.sv
// Sums VEC_LEN signed multiplier products (one per prod_rdy rising edge) into a wrapping accumulator.
// Result appears the cycle after the last capture and is held until acc_ready; stray products set drop.
module mac_accumulator #(
    parameter int WIDTH     = mac_accumulator_pkg::WIDTH,
    parameter int ACC_WIDTH = 20,
    parameter int VEC_LEN   = 4,
    parameter int CNT_W     = 8
) (
    input logic              clk,
    input logic              reset,
    mac_accumulator_if.slave bus
);
    import mac_accumulator_pkg::*;

    localparam int PW = 2 * WIDTH;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   drop_q, drop_d;

    logic                   cap_evt;
    logic signed [PW-1:0]   prod_s;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   sum_ovf;

    mac_accumulator_rdy_edge_detect u_rdy_edge (
        .clk   (clk),
        .reset (reset),
        .rdy_i (bus.prod_rdy),
        .evt_o (cap_evt)
    );

    assign prod_s   = $signed(bus.prod_in);
    assign prod_ext = ACC_WIDTH'(prod_s);
    assign acc_sum  = acc_q + prod_ext;
    assign sum_ovf  = signed_add_ovf(acc_q[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1], acc_sum[ACC_WIDTH-1]);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    drop_d  = 1'b0;
                end else if (cap_evt) begin
                    drop_d  = 1'b1;
                end
            end

            ACCUM: begin
                // A restart wins over a product landing in the same cycle; that product is simply lost.
                if (bus.start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (cap_evt) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (sum_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_inc == CNT_W'(VEC_LEN)) begin
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (cap_evt) begin
                    drop_d = 1'b1;
                end
                if (bus.acc_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.acc_out   = acc_q;
    assign bus.acc_valid = (state_q == HOLD);
    assign bus.busy      = (state_q == ACCUM);
    assign bus.ovf       = ovf_q;
    assign bus.drop      = drop_q;
    assign bus.count     = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboarded bench: a dot-product reference model queues expected results, monitors compare on handshake.
// Instance 0 uses the default 20-bit accumulator, instance 1 a 17-bit one to reach overflow.
module tb_mac_accumulator;
    import mac_accumulator_pkg::*;

    localparam int AW0 = 20;
    localparam int AW1 = 17;
    localparam int VL  = 4;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(AW0), .CNT_W(CW)) if0 ();
    mac_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(AW1), .CNT_W(CW)) if1 ();

    mac_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(AW0), .VEC_LEN(VL), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    mac_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(AW1), .VEC_LEN(VL), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));

    typedef struct {
        longint acc;
        bit     ovf;
        int     cnt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // Model view of each consumer: 0 = not collecting, 1 = collecting, 2 = result waiting
    int   m0_mode = 0, m1_mode = 0;
    int   m0_vec[$], m1_vec[$];
    bit   m0_drop = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain integer dot product, wrapped to aw bits; overflow flagged if any running sum leaves range
    function automatic exp_t ref_vec(input int v[$], input int aw);
        exp_t   r;
        longint lim = longint'(1) << (aw - 1);
        longint run = 0;
        longint t;
        r.ovf = 1'b0;
        foreach (v[i]) begin
            t = run + v[i];
            if (t >= lim || t < -lim) r.ovf = 1'b1;
            if (t >= lim) t = t - 2 * lim;
            else if (t < -lim) t = t + 2 * lim;
            run = t;
        end
        r.acc = run & (2 * lim - 1);
        r.cnt = v.size();
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && if0.acc_valid && if0.acc_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result0: got acc 0x%0h, expected no result", if0.acc_out);
            end else begin
                e0 = q0.pop_front();
                chk("result0_acc", if0.acc_out, e0.acc);
                chk("result0_ovf", if0.ovf, e0.ovf);
                chk("result0_count", if0.count, e0.cnt);
            end
            m0_mode = 0;
        end
        if (!reset && if1.acc_valid && if1.acc_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result1: got acc 0x%0h, expected no result", if1.acc_out);
            end else begin
                e1 = q1.pop_front();
                chk("result1_acc", if1.acc_out, e1.acc);
                chk("result1_ovf", if1.ovf, e1.ovf);
                chk("result1_count", if1.count, e1.cnt);
            end
            m1_mode = 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_prod(input int s, input int p);
        if (s == 0) begin
            if (m0_mode == 1) begin
                m0_vec.push_back(p);
                if (m0_vec.size() == VL) begin
                    q0.push_back(ref_vec(m0_vec, AW0));
                    m0_mode = 2;
                end
            end else begin
                m0_drop = 1'b1;
            end
        end else if (m1_mode == 1) begin
            m1_vec.push_back(p);
            if (m1_vec.size() == VL) begin
                q1.push_back(ref_vec(m1_vec, AW1));
                m1_mode = 2;
            end
        end
    endtask

    task automatic prod(input int s, input int p, input int hi, input int lo);
        model_prod(s, p);
        if (s == 0) begin if0.prod_in = PROD_W'(p); if0.prod_rdy = 1'b1; end
        else        begin if1.prod_in = PROD_W'(p); if1.prod_rdy = 1'b1; end
        tick(hi);
        if0.prod_rdy = 1'b0;
        if1.prod_rdy = 1'b0;
        tick(lo);
    endtask

    task automatic do_start(input int s);
        if (s == 0) begin
            if0.start = 1'b1;
            if (m0_mode == 0) m0_drop = 1'b0;
            if (m0_mode != 2) begin m0_mode = 1; m0_vec.delete(); end
        end else begin
            if1.start = 1'b1;
            if (m1_mode != 2) begin m1_mode = 1; m1_vec.delete(); end
        end
        tick();
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_result(input int s);
        bit done = 1'b0;
        if (s == 0) if0.acc_ready = 1'b1;
        else        if1.acc_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = (s == 0) ? (q0.size() == 0 && m0_mode == 0) : (q1.size() == 0 && m1_mode == 0);
            if (!done) tick();
        end
        chk((s == 0) ? "handshake0_done" : "handshake1_done", longint'(done), 1);
        if0.acc_ready = 1'b0;
        if1.acc_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected end before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        reset = 1'b1;
        if0.start = 0; if0.prod_in = '0; if0.prod_rdy = 0; if0.acc_ready = 0;
        if1.start = 0; if1.prod_in = '0; if1.prod_rdy = 0; if1.acc_ready = 0;
        tick(2);
        chk("rst_acc_out", if0.acc_out, 0);
        chk("rst_acc_valid", if0.acc_valid, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_ovf", if0.ovf, 0);
        chk("rst_drop", if0.drop, 0);
        chk("rst_count", if0.count, 0);
        reset = 1'b0;
        tick();

        // Basic dot product 15 - 14 + 100 - 1
        do_start(0);
        chk("basic_busy", if0.busy, 1);
        prod(0, 15, 3, 1);
        prod(0, -14, 3, 1);
        prod(0, 100, 3, 1);
        model_prod(0, -1);
        if0.prod_in = 16'hFFFF; if0.prod_rdy = 1'b1;
        chk("basic_valid_before", if0.acc_valid, 0);
        tick();
        chk("basic_valid_after", if0.acc_valid, 1);
        chk("basic_acc", if0.acc_out, 'h64);
        chk("basic_count", if0.count, 4);
        chk("basic_busy_hold", if0.busy, 0);
        tick(2);
        if0.prod_rdy = 1'b0;
        tick();
        chk("basic_drop", if0.drop, 0);
        wait_result(0);
        chk("basic_valid_cleared", if0.acc_valid, 0);
        chk("basic_acc_retained", if0.acc_out, 'h64);

        // Level held high captures once; then restarts, including one colliding with a capture
        do_start(0);
        prod(0, 7, 20, 2);
        chk("level_count", if0.count, 1);
        chk("level_acc", if0.acc_out, 7);
        do_start(0);
        chk("restart1_count", if0.count, 0);
        chk("restart1_acc", if0.acc_out, 0);
        prod(0, 10, 2, 1);
        prod(0, 20, 2, 1);
        chk("restart_pre_count", if0.count, 2);
        chk("restart_pre_acc", if0.acc_out, 30);
        if0.prod_in = PROD_W'(9); if0.prod_rdy = 1'b1; if0.start = 1'b1;
        m0_vec.delete();
        tick();
        if0.start = 1'b0;
        chk("restart2_count", if0.count, 0);
        chk("restart2_acc", if0.acc_out, 0);
        chk("restart2_busy", if0.busy, 1);
        chk("restart2_drop", if0.drop, 0);
        if0.prod_rdy = 1'b0;
        tick();
        for (int k = 0; k < VL; k++) prod(0, 1, 1, 1);
        wait_result(0);

        // Backpressure in HOLD with a stray product, then start alongside acc_ready
        do_start(0);
        for (int k = 0; k < VL; k++) prod(0, k + 2, 1, 1);
        chk("bp_valid", if0.acc_valid, 1);
        prod(0, 5, 1, 1);
        tick(8);
        chk("bp_acc_stable", if0.acc_out, 14);
        chk("bp_drop", if0.drop, 1);
        chk("bp_count", if0.count, 4);
        if0.start = 1'b1; if0.acc_ready = 1'b1;
        tick();
        if0.start = 1'b0; if0.acc_ready = 1'b0;
        chk("bp_valid_cleared", if0.acc_valid, 0);
        chk("bp_start_ignored", if0.busy, 0);
        chk("bp_acc_retained", if0.acc_out, 14);

        // Overflow on the 17-bit instance: 4 x 16384 wraps to -65536
        do_start(1);
        for (int k = 0; k < VL; k++) prod(1, 16384, 2, 1);
        chk("ovf_flag_hold", if1.ovf, 1);
        wait_result(1);

        // Randomized vectors
        for (int v = 0; v < 15; v++) begin
            do_start(0);
            if0.acc_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < VL; k++) begin
                p = int'(shortint'($urandom()));
                prod(0, p, $urandom_range(1, 3), $urandom_range(1, 2));
            end
            if ($urandom_range(0, 2) == 0) prod(0, int'(shortint'($urandom())), 1, 1);
            tick($urandom_range(0, 3));
            chk("rand_drop", if0.drop, m0_drop);
            wait_result(0);
        end

        // Asynchronous reset in the middle of a vector
        do_start(0);
        prod(0, 3, 1, 1);
        prod(0, 4, 1, 1);
        chk("arst_pre_count", if0.count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_acc", if0.acc_out, 0);
        chk("arst_busy", if0.busy, 0);
        chk("arst_count", if0.count, 0);
        chk("arst_valid", if0.acc_valid, 0);
        m0_mode = 0; m0_vec.delete(); m0_drop = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        prod(0, 5, 1, 1);
        chk("arst_drop_after", if0.drop, m0_drop);
        chk("arst_acc_after", if0.acc_out, 0);
        chk("arst_count_after", if0.count, 0);
        chk("arst_idle_after", if0.busy, 0);

        tick(2);
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
